zap_postalu_elastic: RTL and testbench

- Parametrised successor of the post-ALU register stage. Sits between the ALU/DCACHE-request stage and the memory/writeback stage.
- Replaces the single stall-gated flop with a DEPTH-entry elastic buffer using a valid/ready handshake on both sides.
- Carries a generic payload plus a 5-bit exception vector.
- Keeps the existing semantics: flush from writeback, and sleep-on-data-fault (the stage stays asleep until writeback flushes it).

---
 rtl/zap_postalu_elastic.sv | 195 +++++++++++++++++++
 tb/tb_zap_postalu_elastic.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/zap_postalu_elastic.sv
// ---------------------------------------------------------------------------
// zap_postalu_elastic
//   Elastic post-ALU register stage that sits between the ALU/DCACHE-request
//   stage and the memory/writeback stage. It holds up to DEPTH beats in FIFO
//   order, with a valid/ready handshake on both sides. Each beat is an opaque
//   payload plus a 5-bit exception vector.
//
//   A flush from writeback (i_clear) empties the stage. A data memory fault
//   (i_fault) also empties it. With SLEEP_ON_FAULT=1 the fault additionally
//   puts the stage to sleep until the next flush or reset.
//
// Ports
//   i_clk      clock
//   i_reset    synchronous, active-high reset
//   i_clear    flush from writeback (empties the stage, wakes it)
//   i_fault    data memory fault (empties the stage, optionally sleeps it)
//   i_valid    upstream beat valid
//   o_ready    stage can accept a beat (depends on state only)
//   i_payload  upstream payload
//   i_exc      upstream exception vector {abt,irq,fiq,swi,und}
//   o_valid    downstream beat valid
//   i_ready    downstream accepts
//   o_payload  head-of-buffer payload
//   o_exc      head-of-buffer exception vector, zero when o_valid=0
//   o_sleep    stage asleep after a fault
//   o_count    current occupancy
// ---------------------------------------------------------------------------
module zap_postalu_elastic #(
  parameter int PAYLOAD_W      = 128,
  parameter int DEPTH          = 2,
  parameter bit SLEEP_ON_FAULT = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clear,
  input  logic                         i_fault,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [PAYLOAD_W-1:0]         i_payload,
  input  logic [4:0]                   i_exc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [PAYLOAD_W-1:0]         o_payload,
  output logic [4:0]                   o_exc,
  output logic                         o_sleep,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Storage: payload and exception are written and read as one entry.
  logic [PAYLOAD_W-1:0] mem_payload_r [DEPTH];
  logic [4:0]           mem_exc_r     [DEPTH];

  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             sleep_r;
  logic             valid_r;
  logic             ready_r;

  logic [CNT_W-1:0] count_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic             sleep_nxt_s;
  logic             wr_en_s;
  logic             push_s;
  logic             pop_s;

  // Handshake qualifiers; valid_r/ready_r are registered from next state so
  // neither side sees a combinational path from the other.
  assign push_s = i_valid && ready_r;
  assign pop_s  = valid_r && i_ready;

  // Next-state: clear beats fault beats normal traffic. A fault while asleep
  // is ignored; push/pop are already blocked by sleep in that case.
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    sleep_nxt_s  = sleep_r;
    wr_en_s      = 1'b0;
    if (i_clear) begin
      count_nxt_s  = {CNT_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      sleep_nxt_s  = 1'b0;
    end else if (i_fault && !sleep_r) begin
      // The concurrent pop (if any) still completes downstream; the
      // concurrent push is dropped by simply not writing it.
      count_nxt_s  = {CNT_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      sleep_nxt_s  = SLEEP_ON_FAULT;
    end else begin
      if (push_s) begin
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_en_s      = 1'b0;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state registers, including the registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      sleep_r  <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      count_r  <= count_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      sleep_r  <= sleep_nxt_s;
      valid_r  <= (count_nxt_s != {CNT_W{1'b0}}) && !sleep_nxt_s;
      ready_r  <= (count_nxt_s != CNT_FULL) && !sleep_nxt_s;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge i_clk) begin
    if (wr_en_s && !i_reset) begin
      mem_payload_r[wr_ptr_r] <= i_payload;
      mem_exc_r[wr_ptr_r]     <= i_exc;
    end
  end

  assign o_ready   = ready_r;
  assign o_valid   = valid_r;
  assign o_payload = mem_payload_r[rd_ptr_r];
  assign o_exc     = valid_r ? mem_exc_r[rd_ptr_r] : 5'b00000;
  assign o_sleep   = sleep_r;
  assign o_count   = count_r;

  zap_postalu_elastic_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .count   (count_r),
    .push    (push_s)
  );

endmodule

// ---------------------------------------------------------------------------
// zap_postalu_elastic_chk
//   Simulation-only structural checks for zap_postalu_elastic.
// Ports
//   i_clk, i_reset  clock and synchronous reset of the checked stage
//   count           current occupancy
//   push            a beat is being accepted this cycle
// ---------------------------------------------------------------------------
module zap_postalu_elastic_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             i_clk,
  input logic             i_reset,
  input logic [CNT_W-1:0] count,
  input logic             push
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  a_depth_pow2: assert property (@(posedge i_clk)
    (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    count <= CNT_FULL);

  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push && (count == CNT_FULL)));

endmodule

// File: tb/tb_zap_postalu_elastic.sv
module tb_zap_postalu_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        flt;
  logic        vld;
  logic        rdy;
  logic [15:0] pay;
  logic [4:0]  exc;

  // a: DEPTH=2 sleeping, b: DEPTH=4 sleeping, c: DEPTH=2 non-sleeping
  logic        a_ready, a_valid, a_sleep;
  logic [15:0] a_payload;
  logic [4:0]  a_exc;
  logic [1:0]  a_count;
  logic        b_ready, b_valid, b_sleep;
  logic [15:0] b_payload;
  logic [4:0]  b_exc;
  logic [2:0]  b_count;
  logic        c_ready, c_valid, c_sleep;
  logic [15:0] c_payload;
  logic [4:0]  c_exc;
  logic [1:0]  c_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  zap_postalu_elastic #(.PAYLOAD_W(16), .DEPTH(2), .SLEEP_ON_FAULT(1'b1)) u_a (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_fault(flt),
    .i_valid(vld), .o_ready(a_ready), .i_payload(pay), .i_exc(exc),
    .o_valid(a_valid), .i_ready(rdy), .o_payload(a_payload), .o_exc(a_exc),
    .o_sleep(a_sleep), .o_count(a_count));

  zap_postalu_elastic #(.PAYLOAD_W(16), .DEPTH(4), .SLEEP_ON_FAULT(1'b1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_fault(flt),
    .i_valid(vld), .o_ready(b_ready), .i_payload(pay), .i_exc(exc),
    .o_valid(b_valid), .i_ready(rdy), .o_payload(b_payload), .o_exc(b_exc),
    .o_sleep(b_sleep), .o_count(b_count));

  zap_postalu_elastic #(.PAYLOAD_W(16), .DEPTH(2), .SLEEP_ON_FAULT(1'b0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_fault(flt),
    .i_valid(vld), .o_ready(c_ready), .i_payload(pay), .i_exc(exc),
    .o_valid(c_valid), .i_ready(rdy), .o_payload(c_payload), .o_exc(c_exc),
    .o_sleep(c_sleep), .o_count(c_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; flt = 1'b0; vld = 1'b0; rdy = 1'b0;
    pay = 16'h0000; exc = 5'b00000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (a_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", a_ready); else pass_cnt++;
    chk_cnt++; if (a_count !== 2'd0) $display("FAIL reset_count got=%0d exp=0", a_count); else pass_cnt++;
    chk_cnt++; if (a_exc !== 5'b00000) $display("FAIL reset_exc got=%b exp=00000", a_exc); else pass_cnt++;
    chk_cnt++; if (a_sleep !== 1'b0) $display("FAIL reset_sleep got=%b exp=0", a_sleep); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [15:0] ev;
    logic [4:0]  ee;
    do_reset();
    rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ev = 16'(k);
      ee = 5'(k);
      vld = 1'b1; pay = ev; exc = ee;
      tick();
      chk_cnt++; if (a_valid !== 1'b1) $display("FAIL stream_valid beat=%0d got=%b exp=1", k, a_valid); else pass_cnt++;
      chk_cnt++; if (a_payload !== ev) $display("FAIL stream_payload got=%h exp=%h", a_payload, ev); else pass_cnt++;
      chk_cnt++; if (a_exc !== ee) $display("FAIL stream_exc got=%b exp=%b", a_exc, ee); else pass_cnt++;
      chk_cnt++; if (a_count !== 2'd1) $display("FAIL stream_count got=%0d exp=1", a_count); else pass_cnt++;
    end
    vld = 1'b0; exc = 5'b00000;
    tick();
    chk_cnt++; if (a_valid !== 1'b0) $display("FAIL stream_drain_valid got=%b exp=0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_count !== 2'd0) $display("FAIL stream_drain_count got=%0d exp=0", a_count); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 1'b0;
    vld = 1'b1; pay = 16'h000A; tick();
    pay = 16'h000B; tick();
    chk_cnt++; if (a_count !== 2'd2) $display("FAIL bp_full_count got=%0d exp=2", a_count); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", a_ready); else pass_cnt++;
    pay = 16'h000C; tick();
    chk_cnt++; if (a_count !== 2'd2) $display("FAIL bp_reject_count got=%0d exp=2", a_count); else pass_cnt++;
    chk_cnt++; if (a_payload !== 16'h000A) $display("FAIL bp_head_a got=%h exp=000a", a_payload); else pass_cnt++;
    vld = 1'b0; rdy = 1'b1;
    tick();
    chk_cnt++; if (a_payload !== 16'h000B) $display("FAIL bp_head_b got=%h exp=000b", a_payload); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL bp_ready_again got=%b exp=1", a_ready); else pass_cnt++;
    chk_cnt++; if (a_count !== 2'd1) $display("FAIL bp_count_1 got=%0d exp=1", a_count); else pass_cnt++;
    tick();
    chk_cnt++; if (a_valid !== 1'b0) $display("FAIL bp_empty_valid got=%b exp=0", a_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    int max_cnt = 0;
    logic pushing, popping;
    logic [15:0] popv;
    do_reset();
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      vld = (sent < 10);
      pay = 16'(sent);
      rdy = (cyc % 2 == 0);
      pushing = vld && b_ready;
      popping = b_valid && rdy;
      popv    = b_payload;
      tick();
      if (pushing) sent++;
      if (popping) begin
        chk_cnt++; if (popv !== 16'(got)) $display("FAIL wrap_order got=%h exp=%h", popv, 16'(got)); else pass_cnt++;
        got++;
      end
      if (int'(b_count) > max_cnt) max_cnt = int'(b_count);
    end
    vld = 1'b0; rdy = 1'b0;
    chk_cnt++; if (got !== 10) $display("FAIL wrap_total got=%0d exp=10", got); else pass_cnt++;
    chk_cnt++; if (max_cnt > 4) $display("FAIL wrap_max_count got=%0d exp<=4", max_cnt); else pass_cnt++;
    chk_cnt++; if (max_cnt !== 4) $display("FAIL wrap_reached_full got=%0d exp=4", max_cnt); else pass_cnt++;
    chk_cnt++; if (b_count !== 3'd0) $display("FAIL wrap_end_count got=%0d exp=0", b_count); else pass_cnt++;
  endtask

  task automatic test_fault();
    do_reset();
    rdy = 1'b0;
    vld = 1'b1; pay = 16'h0001; tick();
    pay = 16'h0002; tick();
    pay = 16'h0005; flt = 1'b1; tick();
    flt = 1'b0; vld = 1'b0;
    chk_cnt++; if (a_count !== 2'd0) $display("FAIL fault_count got=%0d exp=0", a_count); else pass_cnt++;
    chk_cnt++; if (a_sleep !== 1'b1) $display("FAIL fault_sleep got=%b exp=1", a_sleep); else pass_cnt++;
    chk_cnt++; if (a_valid !== 1'b0) $display("FAIL fault_valid got=%b exp=0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b0) $display("FAIL fault_ready got=%b exp=0", a_ready); else pass_cnt++;
    chk_cnt++; if (c_count !== 2'd0) $display("FAIL nosleep_count got=%0d exp=0", c_count); else pass_cnt++;
    chk_cnt++; if (c_sleep !== 1'b0) $display("FAIL nosleep_sleep got=%b exp=0", c_sleep); else pass_cnt++;
    chk_cnt++; if (c_ready !== 1'b1) $display("FAIL nosleep_ready got=%b exp=1", c_ready); else pass_cnt++;
    vld = 1'b1; pay = 16'h0007; tick();
    vld = 1'b0;
    chk_cnt++; if (c_valid !== 1'b1) $display("FAIL nosleep_push_valid got=%b exp=1", c_valid); else pass_cnt++;
    chk_cnt++; if (c_payload !== 16'h0007) $display("FAIL nosleep_push_payload got=%h exp=0007", c_payload); else pass_cnt++;
    chk_cnt++; if (a_count !== 2'd0) $display("FAIL sleep_ignores_push got=%0d exp=0", a_count); else pass_cnt++;
    chk_cnt++; if (a_sleep !== 1'b1) $display("FAIL sleep_holds got=%b exp=1", a_sleep); else pass_cnt++;
    clr = 1'b1; tick();
    clr = 1'b0;
    chk_cnt++; if (a_sleep !== 1'b0) $display("FAIL clear_sleep got=%b exp=0", a_sleep); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL clear_ready got=%b exp=1", a_ready); else pass_cnt++;
    vld = 1'b1; pay = 16'h0006; tick();
    vld = 1'b0;
    chk_cnt++; if (a_valid !== 1'b1) $display("FAIL wake_valid got=%b exp=1", a_valid); else pass_cnt++;
    chk_cnt++; if (a_payload !== 16'h0006) $display("FAIL wake_payload got=%h exp=0006", a_payload); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    rdy = 1'b0;
    vld = 1'b1; pay = 16'h0011; exc = 5'b10101; tick();
    pay = 16'h0012; tick();
    vld = 1'b0;
    chk_cnt++; if (a_exc !== 5'b10101) $display("FAIL full_exc got=%b exp=10101", a_exc); else pass_cnt++;
    rst = 1'b1; tick();
    rst = 1'b0;
    chk_cnt++; if (a_valid !== 1'b0) $display("FAIL rst_full_valid got=%b exp=0", a_valid); else pass_cnt++;
    chk_cnt++; if (a_exc !== 5'b00000) $display("FAIL rst_full_exc got=%b exp=00000", a_exc); else pass_cnt++;
    chk_cnt++; if (a_count !== 2'd0) $display("FAIL rst_full_count got=%0d exp=0", a_count); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL rst_full_ready got=%b exp=1", a_ready); else pass_cnt++;
    vld = 1'b1; pay = 16'h0021; tick();
    vld = 1'b0; flt = 1'b1; tick();
    flt = 1'b0;
    chk_cnt++; if (a_sleep !== 1'b1) $display("FAIL sim_asleep got=%b exp=1", a_sleep); else pass_cnt++;
    clr = 1'b1; flt = 1'b1; tick();
    clr = 1'b0; flt = 1'b0;
    chk_cnt++; if (a_sleep !== 1'b0) $display("FAIL clr_flt_sleep got=%b exp=0", a_sleep); else pass_cnt++;
    chk_cnt++; if (a_count !== 2'd0) $display("FAIL clr_flt_count got=%0d exp=0", a_count); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL clr_flt_ready got=%b exp=1", a_ready); else pass_cnt++;
    flt = 1'b1; tick();
    flt = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    chk_cnt++; if (a_sleep !== 1'b0) $display("FAIL rst_asleep_sleep got=%b exp=0", a_sleep); else pass_cnt++;
    chk_cnt++; if (a_ready !== 1'b1) $display("FAIL rst_asleep_ready got=%b exp=1", a_ready); else pass_cnt++;
    exc = 5'b00000;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; flt = 1'b0; vld = 1'b0; rdy = 1'b0;
    pay = 16'h0000; exc = 5'b00000;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_fault();
    test_simultaneous();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
